ddr_rd_burst_ctrl: RTL
======================

// Module: ddr_rd_burst_ctrl
// PURPOSE
//   Sequences DDR3 read bursts that fill the 256-bit read-side prefetch FIFO
//   (write side 1024 x 256). Walks one frame-buffer region per frame and
//   issues AXI-style AR bursts only when the FIFO has guaranteed room.
//   Returned beats are registered into the FIFO write port.
//   Sits between the DDR3 controller read channel and the FIFO write port,
//   in the DDR clock domain.
// PARAMETERS
//   ADDR_W        28   DDR byte-address width
//   DATA_W        256  beat width; one beat = DATA_W/8 = 32 bytes
//   BURST_LEN     16   beats per full burst (1..256)
//   FIFO_DEPTH_W  10   FIFO write-side depth = 2**FIFO_DEPTH_W words
//   FRAME_BEATS_W 20   width of the frame length, counted in beats
// PORTS
//   clk           in   1              DDR user clock
//   rst_n         in   1              asynchronous reset, active low
//   frame_start   in   1              pulse; starts one frame
//   frame_base    in   ADDR_W         frame byte base, 32-byte aligned
//   frame_beats   in   FRAME_BEATS_W  beats per frame; 0 = no-op
//   busy          out  1              frame in progress
//   frame_done    out  1              1-cycle pulse, last beat written
//   err_unexp     out  1              sticky; beat arrived with no outstanding request
//   ar_valid      out  1              read request valid
//   ar_ready      in   1              read request accepted
//   ar_addr       out  ADDR_W         burst byte address
//   ar_len        out  8              beats-1
//   r_valid       in   1              read beat valid
//   r_data        in   DATA_W         read beat data
//   r_last        in   1              last beat of burst (informational)
//   r_ready       out  1              tied 1 while rst_n=1
//   fifo_wr_cnt   in   FIFO_DEPTH_W+1 FIFO write-side fill level
//   fifo_wr_en    out  1              FIFO write enable
//   fifo_wr_data  out  DATA_W         FIFO write data
// BEHAVIOUR
//   Reset values: all outputs 0 except r_ready (1 after reset release).
//   Reset clears all counters and the FSM. Beats still in flight at reset are discarded.
//   FSM states:
//     IDLE -> CHECK on frame_start with frame_beats!=0.
//       Latch base/beats. Set busy the next cycle.
//       frame_start with frame_beats==0: frame_done pulses next cycle; busy stays 0.
//       frame_start while busy=1 is ignored.
//     CHECK -> REQ when the space test passes; otherwise stay in CHECK.
//       Space test: fifo_wr_cnt + outstanding + pipe_vld + len <= 2**FIFO_DEPTH_W.
//       len = min(BURST_LEN, beats_left_to_request).
//     REQ: ar_valid=1; ar_addr and ar_len are held stable until ar_ready.
//       On handshake: outstanding += len, addr += len*32, req_left -= len.
//       -> CHECK if req_left>0, else -> DRAIN.
//     DRAIN -> IDLE when rcv_cnt == frame_beats.
//       frame_done pulses in that cycle; busy falls the next cycle.
//   ar_valid is earliest 2 cycles after frame_start: latch cycle, then CHECK.
//   Last burst is shortened when frame_beats % BURST_LEN != 0.
//     Example: frame_beats=40, BURST_LEN=16 gives ar_len 15, 15, 7.
//   Read data path: each r_valid beat is registered into fifo_wr_data, and
//     fifo_wr_en asserts exactly 1 cycle later (pipe_vld).
//     Each beat does outstanding -= 1 and rcv_cnt += 1.
//   An AR handshake and a beat in the same cycle apply both updates:
//     net change = len - 1.
//   outstanding width is FIFO_DEPTH_W+1 and never exceeds the depth.
//   The FIFO never overflows by construction.
//   Address arithmetic is modulo 2**ADDR_W; wrap-around is silent.
//   err_unexp sets when r_valid=1 and outstanding=0. The beat is dropped
//     (not written to the FIFO). Cleared only by reset.
//   fifo_wr_cnt is treated as a conservative upper bound; the test uses it directly.
// CONFIGURATION
//   DDR_RD_PINGPONG_EN defined:
//     Adds input frame_base1 (ADDR_W) and output buf_sel (1, reset 0).
//     Each frame reads from frame_base when buf_sel=0, frame_base1 when buf_sel=1.
//     buf_sel toggles on every frame_done.
//   DDR_RD_PINGPONG_EN undefined:
//     No extra ports; every frame reads from frame_base.
// STRUCTURE
//   Package ddr_rd_pkg:
//     FSM state enum (IDLE, CHECK, REQ, DRAIN).
//     BEAT_BYTES=32 constant.
//     Space-test function fifo_has_room().
//   Sub-module ddr_rd_addr_gen: address/length generator.
//     Holds next address, req_left, computes len.
//   Top block keeps the FSM, credit counters and the data register.
// TESTING
//   1. frame_beats=64, BURST_LEN=16, ar_ready=1, fifo_wr_cnt=0, data returned 4 cycles after AR
//      -> 4 bursts at base+0/512/1024/1536 with ar_len=15; 64 fifo_wr_en; one frame_done.
//   2. frame_beats=40 -> ar_len sequence 15,15,7; last ar_addr=base+1024; 40 writes.
//   3. fifo_wr_cnt=1010, no beats returning
//      -> no ar_valid (1010+16>1024); drop fifo_wr_cnt to 1008 -> one burst issued.
//   4. ar_ready held 0 for 10 cycles -> ar_valid, ar_addr, ar_len stable the whole time;
//      handshake and r beat in same cycle -> outstanding nets +15.
//   5. r_valid while idle -> err_unexp=1, no fifo_wr_en;
//      rst_n pulse mid-frame -> all outputs 0, busy=0, err_unexp cleared.
//   6. DDR_RD_PINGPONG_EN: three frames -> bases base0, base1, base0; buf_sel 0->1->0.

Source files
------------

// File: rtl/ddr_rd_pkg.sv
// Shared types and helpers for the DDR3 read-burst sequencer.
// Holds the FSM state encoding, beat size and the FIFO space test.
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } rd_state_t;

    localparam int unsigned BEAT_BYTES = 32;
    localparam int unsigned LEN_W      = 9;

    // A burst may issue only if every word that could land in the FIFO still fits.
    function automatic logic fifo_has_room(
        input int unsigned wr_cnt,
        input int unsigned outstanding,
        input int unsigned pipe_vld,
        input int unsigned len,
        input int unsigned depth
    );
        return (wr_cnt + outstanding + pipe_vld + len) <= depth;
    endfunction

endpackage

// File: rtl/ddr_rd_addr_gen.sv
// Burst address/length generator: tracks the next burst address and the
// number of beats still to be requested for the current frame.
module ddr_rd_addr_gen
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_W        = 28,
    parameter int FRAME_BEATS_W = 20,
    parameter int BURST_LEN     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        load_base,
    input  logic [FRAME_BEATS_W-1:0] load_beats,
    input  logic                     advance,
    output logic [ADDR_W-1:0]        addr,
    output logic [LEN_W-1:0]         len,
    output logic                     last
);

    logic [ADDR_W-1:0]        addr_reg;
    logic [FRAME_BEATS_W-1:0] req_left_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            req_left_reg <= '0;
        end else if (load) begin
            addr_reg     <= load_base;
            req_left_reg <= load_beats;
        end else if (advance) begin
            // Address wraps silently modulo 2**ADDR_W.
            addr_reg     <= addr_reg + ADDR_W'(len) * ADDR_W'(BEAT_BYTES);
            req_left_reg <= req_left_reg - FRAME_BEATS_W'(len);
        end
    end

    always_comb begin
        len = LEN_W'(BURST_LEN);
        if (req_left_reg < FRAME_BEATS_W'(BURST_LEN)) begin
            len = LEN_W'(req_left_reg);
        end
    end

    assign addr = addr_reg;
    assign last = (req_left_reg == FRAME_BEATS_W'(len));

endmodule

// File: rtl/ddr_rd_burst_ctrl.sv
// DDR3 read-burst sequencer feeding the read-side prefetch FIFO.
// Optional DDR_RD_PINGPONG_EN adds a second frame base and alternates buffers per frame.
module ddr_rd_burst_ctrl
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_W        = 28,
    parameter int DATA_W        = 256,
    parameter int BURST_LEN     = 16,
    parameter int FIFO_DEPTH_W  = 10,
    parameter int FRAME_BEATS_W = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef DDR_RD_PINGPONG_EN
    input  logic [ADDR_W-1:0]        frame_base1,
    output logic                     buf_sel,
`endif
    input  logic                     frame_start,
    input  logic [ADDR_W-1:0]        frame_base,
    input  logic [FRAME_BEATS_W-1:0] frame_beats,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err_unexp,
    output logic                     ar_valid,
    input  logic                     ar_ready,
    output logic [ADDR_W-1:0]        ar_addr,
    output logic [7:0]               ar_len,
    input  logic                     r_valid,
    input  logic [DATA_W-1:0]        r_data,
    input  logic                     r_last,
    output logic                     r_ready,
    input  logic [FIFO_DEPTH_W:0]    fifo_wr_cnt,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        fifo_wr_data
);

    localparam int          CNT_W      = FIFO_DEPTH_W + 1;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_W;

    rd_state_t                state_reg, state_next;
    logic [FRAME_BEATS_W-1:0] beats_reg, rcv_cnt_reg;
    logic [CNT_W-1:0]         outstanding_reg;
    logic                     pipe_vld_reg;
    logic [DATA_W-1:0]        data_reg;
    logic                     err_reg;
    logic                     zero_done_reg;

    logic [ADDR_W-1:0] start_base, gen_addr;
    logic [LEN_W-1:0]  gen_len;
    logic              gen_last;
    logic              start_ok, start_zero, ar_hs, beat_ok, has_room, drain_done;
    logic              unused_r_last;

    assign unused_r_last = r_last;

    assign start_ok   = (state_reg == IDLE) && frame_start && (frame_beats != '0);
    assign start_zero = (state_reg == IDLE) && frame_start && (frame_beats == '0);
    assign ar_hs      = (state_reg == REQ) && ar_ready;
    // Beats with no credit outstanding are unexpected and never reach the FIFO.
    assign beat_ok    = r_valid && (outstanding_reg != '0);
    assign drain_done = (state_reg == DRAIN) && (rcv_cnt_reg == beats_reg);
    assign has_room   = fifo_has_room(32'(fifo_wr_cnt), 32'(outstanding_reg),
                                      32'(pipe_vld_reg), 32'(gen_len), FIFO_DEPTH);

`ifdef DDR_RD_PINGPONG_EN
    logic buf_sel_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_sel_reg <= 1'b0;
        end else if (frame_done) begin
            buf_sel_reg <= ~buf_sel_reg;
        end
    end

    assign buf_sel    = buf_sel_reg;
    assign start_base = buf_sel_reg ? frame_base1 : frame_base;
`else
    assign start_base = frame_base;
`endif

    ddr_rd_addr_gen #(
        .ADDR_W        (ADDR_W),
        .FRAME_BEATS_W (FRAME_BEATS_W),
        .BURST_LEN     (BURST_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start_ok),
        .load_base  (start_base),
        .load_beats (frame_beats),
        .advance    (ar_hs),
        .addr       (gen_addr),
        .len        (gen_len),
        .last       (gen_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok)   state_next = CHECK;
            CHECK:   if (has_room)   state_next = REQ;
            REQ:     if (ar_ready)   state_next = gen_last ? DRAIN : CHECK;
            DRAIN:   if (drain_done) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Credit and receive counters; a handshake and a beat in one cycle net to len-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_reg       <= '0;
            rcv_cnt_reg     <= '0;
            outstanding_reg <= '0;
            pipe_vld_reg    <= 1'b0;
            data_reg        <= '0;
            err_reg         <= 1'b0;
            zero_done_reg   <= 1'b0;
        end else begin
            if (start_ok) begin
                beats_reg   <= frame_beats;
                rcv_cnt_reg <= '0;
            end else if (beat_ok) begin
                rcv_cnt_reg <= rcv_cnt_reg + 1'b1;
            end
            outstanding_reg <= outstanding_reg
                               + (ar_hs ? CNT_W'(gen_len) : CNT_W'(0))
                               - CNT_W'(beat_ok);
            pipe_vld_reg    <= beat_ok;
            if (beat_ok) begin
                data_reg <= r_data;
            end
            if (r_valid && (outstanding_reg == '0)) begin
                err_reg <= 1'b1;
            end
            zero_done_reg <= start_zero;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign frame_done   = zero_done_reg || drain_done;
    assign err_unexp    = err_reg;
    assign ar_valid     = (state_reg == REQ);
    assign ar_addr      = ar_valid ? gen_addr : '0;
    assign ar_len       = ar_valid ? 8'(gen_len - 1'b1) : 8'd0;
    assign r_ready      = rst_n;
    assign fifo_wr_en   = pipe_vld_reg;
    assign fifo_wr_data = data_reg;

endmodule
